// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  function automatic int calc_div(input longint clk_rate, input longint baud);
    return int'(clk_rate / baud);
  endfunction

  // Width of a counter that must reach div-1.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with asynchronous reset on its control state; head word is
// visible on dout whenever the FIFO is non-empty.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: input FIFO feeding a frame FSM that emits
// start, data (LSB first), optional parity and stop bits back-to-back.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_RATE    = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_req,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic                          tx_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = calc_div(CLK_RATE, BAUD);
  localparam int CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_RATE/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == PAR_ODD) ? ~^d : ^d;
  endfunction

  uart_state_t          state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 load, bit_end;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_head;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_req),
    .pop   (load),
    .din   (tx_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx_busy  = (state_q != IDLE) || !fifo_empty;
  assign tx_out   = tx_q;
  assign bit_end  = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    if (state_q != IDLE) baud_d = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: begin
        tx_d = UART_IDLE_LVL;
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY_MODE != PAR_NONE) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = UART_IDLE_LVL;
            end
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = UART_IDLE_LVL;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            // A queued word starts on this same edge so frames stay gapless.
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = UART_IDLE_LVL;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = UART_IDLE_LVL;
      end
    endcase
    if (load) begin
      shift_d = fifo_head;
      par_d   = frame_parity(fifo_head);
      baud_d  = '0;
      bit_d   = '0;
      state_d = START;
      tx_d    = UART_START_LVL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= UART_IDLE_LVL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: five configurations at DIV = 16, checked
// bit period by bit period against hand-computed frames.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req;
  logic [7:0] tx_data;
  logic [2:0] sel;

  logic [4:0] o_out, o_ready, o_busy;
  logic [2:0] o_cnt [5];
  logic       mon_out, mon_ready, mon_busy;
  logic [2:0] mon_cnt;

  int tests = 0;
  int fails = 0;
  bit hold_mode, rel_next;
  int ncyc, ready_at;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_RATE(16), .BAUD(1), .DATA_BITS(8), .PARITY_MODE(0),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .clk(clk), .rst(rst), .tx_req(tx_req && sel == 3'd0), .tx_data(tx_data),
    .tx_ready(o_ready[0]), .tx_busy(o_busy[0]), .tx_out(o_out[0]), .fifo_count(o_cnt[0]));

  uart_tx_param #(.CLK_RATE(16), .BAUD(1), .DATA_BITS(8), .PARITY_MODE(1),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .clk(clk), .rst(rst), .tx_req(tx_req && sel == 3'd1), .tx_data(tx_data),
    .tx_ready(o_ready[1]), .tx_busy(o_busy[1]), .tx_out(o_out[1]), .fifo_count(o_cnt[1]));

  uart_tx_param #(.CLK_RATE(16), .BAUD(1), .DATA_BITS(8), .PARITY_MODE(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_o1 (
    .clk(clk), .rst(rst), .tx_req(tx_req && sel == 3'd2), .tx_data(tx_data),
    .tx_ready(o_ready[2]), .tx_busy(o_busy[2]), .tx_out(o_out[2]), .fifo_count(o_cnt[2]));

  uart_tx_param #(.CLK_RATE(16), .BAUD(1), .DATA_BITS(8), .PARITY_MODE(0),
                  .STOP_BITS(2), .FIFO_DEPTH(4)) u_n2 (
    .clk(clk), .rst(rst), .tx_req(tx_req && sel == 3'd3), .tx_data(tx_data),
    .tx_ready(o_ready[3]), .tx_busy(o_busy[3]), .tx_out(o_out[3]), .fifo_count(o_cnt[3]));

  uart_tx_param #(.CLK_RATE(16), .BAUD(1), .DATA_BITS(5), .PARITY_MODE(2),
                  .STOP_BITS(1), .FIFO_DEPTH(4)) u_5o (
    .clk(clk), .rst(rst), .tx_req(tx_req && sel == 3'd4), .tx_data(tx_data[4:0]),
    .tx_ready(o_ready[4]), .tx_busy(o_busy[4]), .tx_out(o_out[4]), .fifo_count(o_cnt[4]));

  always_comb begin
    mon_out   = o_out[sel];
    mon_ready = o_ready[sel];
    mon_busy  = o_busy[sel];
    mon_cnt   = o_cnt[sel];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Walks one frame clock by clock; each bit must hold its level for all 16
  // clocks and tx_busy must stay high. skip = start-bit clocks already consumed.
  task automatic check_frame(input string tag, input logic [7:0] data, input int nbits,
                             input bit has_par, input bit par, input int nstop, input int skip);
    logic bits [13];
    int   nb, good, n, busy_low;
    nb = 0;
    bits[nb] = 1'b0; nb = nb + 1;
    for (int i = 0; i < nbits; i++) begin
      bits[nb] = data[i]; nb = nb + 1;
    end
    if (has_par) begin
      bits[nb] = par; nb = nb + 1;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[nb] = 1'b1; nb = nb + 1;
    end
    busy_low = 0;
    for (int b = 0; b < nb; b++) begin
      good = 0;
      n = (b == 0) ? 16 - skip : 16;
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        if (mon_out === bits[b]) good++;
        if (mon_busy !== 1'b1) busy_low++;
        if (hold_mode) begin
          if (rel_next) begin
            tx_req    = 1'b0;
            hold_mode = 1'b0;
            chk("fifo refilled after pop", 32'(mon_cnt), 4);
          end else if (mon_ready) begin
            ready_at = ncyc;
            rel_next = 1'b1;
            chk("count after first pop", 32'(mon_cnt), 3);
          end
        end
        ncyc++;
      end
      chk($sformatf("%s bit%0d clocks", tag, b), good, n);
    end
    chk({tag, " busy held"}, busy_low, 0);
  endtask

  task automatic send(input string tag, input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req = 1'b0;
    chk({tag, " line idle on accept cycle"}, 32'(mon_out), 1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, " busy after frame"}, 32'(mon_busy), 0);
    chk({tag, " line after frame"}, 32'(mon_out), 1);
  endtask

  logic par_tab [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1; tx_req = 1'b0; tx_data = '0; sel = 3'd0;
    hold_mode = 1'b0; rel_next = 1'b0; ncyc = 0; ready_at = -1;
    repeat (2) @(negedge clk);
    chk("reset tx_out", 32'(mon_out), 1);
    chk("reset tx_ready", 32'(mon_ready), 1);
    chk("reset tx_busy", 32'(mon_busy), 0);
    chk("reset fifo_count", 32'(mon_cnt), 0);
    @(negedge clk);
    rst = 1'b0;

    // 8N1, 0x55
    sel = 3'd0;
    send("8N1", 8'h55);
    check_frame("8N1 55", 8'h55, 8, 1'b0, 1'b0, 1, 0);
    idle_check("8N1");

    // parity variants
    sel = 3'd1;
    send("8E1 A5", 8'hA5);
    check_frame("8E1 A5", 8'hA5, 8, 1'b1, 1'b0, 1, 0);
    idle_check("8E1 A5");
    sel = 3'd2;
    send("8O1 A5", 8'hA5);
    check_frame("8O1 A5", 8'hA5, 8, 1'b1, 1'b1, 1, 0);
    idle_check("8O1 A5");
    sel = 3'd1;
    send("8E1 07", 8'h07);
    check_frame("8E1 07", 8'h07, 8, 1'b1, 1'b1, 1, 0);
    idle_check("8E1 07");

    // FIFO fill with tx_req held for words 1..6
    sel = 3'd1;
    @(negedge clk);
    tx_data = 8'h01; tx_req = 1'b1;
    @(negedge clk);
    chk("burst count after word1", 32'(mon_cnt), 1);
    chk("burst line before start", 32'(mon_out), 1);
    tx_data = 8'h02;
    @(negedge clk);
    chk("burst push+pop count", 32'(mon_cnt), 1);
    tx_data = 8'h03;
    @(negedge clk);
    tx_data = 8'h04;
    @(negedge clk);
    tx_data = 8'h05;
    @(negedge clk);
    chk("burst full count", 32'(mon_cnt), 4);
    chk("burst full ready", 32'(mon_ready), 0);
    tx_data = 8'h06;
    hold_mode = 1'b1; rel_next = 1'b0; ncyc = 4; ready_at = -1;
    for (int w = 1; w <= 6; w++)
      check_frame($sformatf("burst w%0d", w), 8'(w), 8, 1'b1, par_tab[w-1], 1, (w == 1) ? 4 : 0);
    chk("ready returns at end of frame1", ready_at, 176);
    idle_check("burst");

    // 8N2, two queued words
    sel = 3'd3;
    @(negedge clk);
    tx_data = 8'h81; tx_req = 1'b1;
    @(negedge clk);
    chk("8N2 line idle on accept", 32'(mon_out), 1);
    tx_data = 8'h3C;
    @(negedge clk);
    tx_req = 1'b0;
    chk("8N2 count push+pop", 32'(mon_cnt), 1);
    chk("8N2 start level", 32'(mon_out), 0);
    check_frame("8N2 81", 8'h81, 8, 1'b0, 1'b0, 2, 1);
    check_frame("8N2 3C", 8'h3C, 8, 1'b0, 1'b0, 2, 0);
    idle_check("8N2");

    // 5 data bits, odd parity
    sel = 3'd4;
    send("5O1", 8'h1F);
    check_frame("5O1 1F", 8'h1F, 5, 1'b1, 1'b0, 1, 0);
    idle_check("5O1");

    // reset mid-DATA with two words queued
    sel = 3'd1;
    @(negedge clk);
    tx_data = 8'h11; tx_req = 1'b1;
    @(negedge clk);
    tx_data = 8'h22;
    @(negedge clk);
    tx_data = 8'h33;
    @(negedge clk);
    tx_req = 1'b0;
    chk("pre-reset count", 32'(mon_cnt), 2);
    repeat (46) @(negedge clk);
    chk("pre-reset line in data bit1", 32'(mon_out), 0);
    #2 rst = 1'b1;
    #1;
    chk("async reset tx_out", 32'(mon_out), 1);
    chk("async reset fifo_count", 32'(mon_cnt), 0);
    chk("async reset tx_ready", 32'(mon_ready), 1);
    chk("async reset tx_busy", 32'(mon_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    send("post-reset", 8'h3C);
    check_frame("post-reset 3C", 8'h3C, 8, 1'b1, 1'b0, 1, 0);
    idle_check("post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter that generalises the fixed 8-bit, even-parity, single-stop transmitter. It provides configurable data width, parity mode (none/even/odd), one or two stop bits and a baud divisor derived from the clock rate. An input FIFO accepts words from the APB side with a valid/ready handshake, and the block sends queued frames back-to-back with no idle gap.

Parameters:
- CLK_RATE, 50_000_000: input clock frequency in Hz.
- BAUD, 9600: line rate in bit/s. DIV = CLK_RATE/BAUD (integer division) is the number of clocks per bit.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- PARITY_MODE, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries. Power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tx_req  in  1  word valid from the APB side.
- tx_data  in  DATA_BITS  word to transmit.
- tx_ready  out  1  FIFO not full. A word is accepted on a clk edge where tx_req && tx_ready.
- tx_busy  out  1  high while the FSM is not IDLE or the FIFO is non-empty.
- tx_out  out  1  serial line output, idle high, registered.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Single clock domain. rst is asynchronous and active-high.
- Reset values (take effect immediately on rst assertion):
  - tx_out = 1, tx_ready = 1, tx_busy = 0, fifo_count = 0.
  - FSM = IDLE; baud counter, bit counter and shift register = 0.
- Elaboration-time error if any of the following holds: DIV < 2, DATA_BITS outside 5..9, PARITY_MODE > 2, STOP_BITS not 1 or 2, FIFO_DEPTH not a power of two ≥ 2.
- FIFO rules:
  - Push when tx_req && tx_ready. A tx_req while full is ignored; no state changes.
  - Simultaneous push and pop leaves fifo_count unchanged.
- FSM states and transitions:
  - IDLE: tx_out = 1. If the FIFO is non-empty, pop the head into the shift register, compute parity, clear the baud counter and enter START. tx_out <= 0 on the same edge.
  - START: one bit period, tx_out = 0. Then enter DATA.
  - DATA: DATA_BITS bit periods, LSB first. Shift right at each bit boundary. After the last data bit go to PARITY if PARITY_MODE != 0, otherwise to STOP.
  - PARITY: one bit period. Value = XOR of data bits for even mode, inverted XOR for odd mode.
  - STOP: STOP_BITS bit periods, tx_out = 1. At the final clock of the final stop period:
    - FIFO non-empty: pop and go directly to START, so the start bit immediately follows with no idle clock.
    - FIFO empty: go to IDLE.
- Timing:
  - Every bit lasts exactly DIV clocks. The baud counter runs only outside IDLE and restarts at every bit boundary, so the first bit is never shortened.
  - Latency: a word accepted at edge N into an empty FIFO while IDLE drives the start bit (tx_out = 0) from edge N+1.
  - Frame length = (1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS) × DIV clocks.
- Unused high bits of tx_data do not exist: the port width equals DATA_BITS.
- Reset mid-frame: line returns high at once, FIFO is flushed and the partial frame is abandoned. The next accepted word produces a complete, clean frame.

Decomposition:
- Package uart_pkg contains:
  - the state enum {IDLE, START, DATA, PARITY, STOP};
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - line level constants UART_IDLE_LVL = 1 and UART_START_LVL = 0;
  - a function computing DIV and the counter width.
- One sub-module: uart_tx_fifo. It is a synchronous FIFO with async reset, parameterised by width and depth, with push/pop/full/empty/count ports.

Test Plan:
All tests use CLK_RATE = 16 and BAUD = 1, giving DIV = 16.
1. 8N1 (PARITY_MODE = 0), write 0x55 → tx_out low from the clock after accept for 16 clocks; then 1,0,1,0,1,0,1,0 at 16 clocks each; then high for 16. tx_busy falls 160 clocks after the start edge.
2. 8E1 with 0xA5 → parity bit 0. 8O1 with 0xA5 → parity 1. 8E1 with 0x07 → parity 1. Frame = 176 clocks.
3. FIFO_DEPTH = 4, tx_req held high for 6 consecutive cycles (words 0x01..0x06):
   - word 1 is popped immediately;
   - words 2..5 fill the FIFO, fifo_count = 4 and tx_ready = 0;
   - word 6 is held until the first pop at the end of frame 1, then accepted;
   - all six frames appear in order, back-to-back, with no idle clock between stop and start.
4. STOP_BITS = 2, 8N2, two queued words → stop level lasts exactly 32 clocks between frames; tx_busy stays high throughout.
5. DATA_BITS = 5, PARITY_MODE = 2, write 0x1F → start, five 1s, parity 0, stop. Frame = 128 clocks.
6. Assert rst mid-DATA with 2 words queued → in the same cycle tx_out = 1, fifo_count = 0, tx_ready = 1, tx_busy = 0. After release, writing 0x3C yields one correct 8-bit frame with parity per PARITY_MODE.
